// File: rtl/fifo_flags_if.sv
// Producer/consumer side of the fifo_flags buffer: push/pop controls in, head word and status out.
// rd and wr are level-sampled on every rising edge; a push lands only while full=0 (or when paired with a pop),
// a pop only while empty=0. There is no other handshake.
interface fifo_flags_if #(
  parameter int B = 8,
  parameter int W = 4
);
  logic         rd;
  logic         wr;
  logic [B-1:0] w_data;
  logic         clr_err;
  logic [B-1:0] r_data;
  logic         empty;
  logic         full;
  logic         almost_empty;
  logic         almost_full;
  logic [W:0]   count;
  logic         overflow;
  logic         underflow;

  modport master (
    output rd, wr, w_data, clr_err,
    input  r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  rd, wr, w_data, clr_err,
    output r_data, empty, full, almost_empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// Show-ahead synchronous FIFO with occupancy count, programmable almost flags and sticky error flags.
// Every status output is decoded from the registered count; only pointers, count and error bits hold state.
module fifo_flags #(
  parameter int B  = 8,
  parameter int W  = 4,
  parameter int AF = (1 << W) - 2,
  parameter int AE = 1
) (
  input  logic        clk,
  input  logic        reset,
  fifo_flags_if.slave bus
);
  localparam int         DEPTH   = 1 << W;
  localparam logic [W:0] DEPTH_C = (W + 1)'(DEPTH);
  localparam logic [W:0] AF_C    = (W + 1)'(AF);
  localparam logic [W:0] AE_C    = (W + 1)'(AE);
  localparam logic [W:0] ONE_C   = (W + 1)'(1);

  if (AF < 1 || AF > DEPTH) begin : g_bad_af
    $error("fifo_flags: AF=%0d outside 1..%0d", AF, DEPTH);
  end
  if (AE < 0 || AE > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flags: AE=%0d outside 0..%0d", AE, DEPTH - 1);
  end

  logic [B-1:0] mem_q [DEPTH];
  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;
  logic         empty_s, full_s;
  logic         wr_acc, rd_acc, set_ovf, set_udf;

  assign empty_s = (count_q == '0);
  assign full_s  = (count_q == DEPTH_C);

  // A pop in the same cycle frees the slot, so a full FIFO still accepts a paired push.
  assign wr_acc  = bus.wr && (!full_s || bus.rd);
  assign rd_acc  = bus.rd && !empty_s;
  assign set_ovf = bus.wr && full_s && !bus.rd;
  assign set_udf = bus.rd && empty_s;

  always_comb begin
    w_ptr_d = w_ptr_q + W'(wr_acc);
    r_ptr_d = r_ptr_q + W'(rd_acc);
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    ovf_d = set_ovf | (ovf_q & ~bus.clr_err);
    udf_d = set_udf | (udf_q & ~bus.clr_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage carries no reset; a stray write while reset is low is invisible because count stays 0.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[w_ptr_q] <= bus.w_data;
  end

  assign bus.r_data       = mem_q[r_ptr_q];
  assign bus.empty        = empty_s;
  assign bus.full         = full_s;
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// Bench for fifo_flags (B=8, W=2, AF=3, AE=1): directed scenarios plus a seeded random run against a queue model.
module tb_fifo_flags;
  localparam int B = 8;
  localparam int W = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [B-1:0] exp_q[$];
  logic [B-1:0] mdl_q[$];

  fifo_flags_if #(.B(B), .W(W)) bus ();

  fifo_flags #(.B(B), .W(W), .AF(3), .AE(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- monitor: pops expected head word on every accepted read ----------------
  always @(negedge clk) begin
    if (reset && bus.rd && !bus.empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: unexpected read, got %02h with no expected word", bus.r_data);
      end else begin
        logic [B-1:0] e;
        e = exp_q.pop_front();
        if (bus.r_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %02h expected %02h", bus.r_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic r, input logic w, input logic [B-1:0] d, input logic c);
    bus.rd      = r;
    bus.wr      = w;
    bus.w_data  = d;
    bus.clr_err = c;
    @(posedge clk);
    #1;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic expect_read(input logic [B-1:0] d);
    exp_q.push_back(d);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic chk_stat(input string nm, input int c, input bit e, input bit f,
                          input bit ae, input bit af, input bit ov, input bit un);
    logic [8:0] act, req;
    act = {bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full, bus.overflow, bus.underflow};
    req = {3'(c), e, f, ae, af, ov, un};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: {count,empty,full,ae,af,ovf,udf} got %0d,%b%b%b%b%b%b expected %0d,%b%b%b%b%b%b",
               nm, act[8:6], act[5], act[4], act[3], act[2], act[1], act[0],
               req[8:6], req[5], req[4], req[3], req[2], req[1], req[0]);
    end
  endtask

  task automatic chk_data(input string nm, input logic [B-1:0] d);
    checks++;
    if (bus.r_data !== d) begin
      errors++;
      $display("FAIL %s: r_data got %02h expected %02h", nm, bus.r_data, d);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.w_data  = '0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_stat("reset_state", 0, 1, 0, 1, 0, 0, 0);
    reset = 1'b1;

    // scenario 1: fill
    cyc(1'b0, 1'b1, 8'h11, 1'b0); chk_stat("fill1", 1, 0, 0, 1, 0, 0, 0);
    chk_data("head_after_first_write", 8'h11);
    cyc(1'b0, 1'b1, 8'h22, 1'b0); chk_stat("fill2", 2, 0, 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b1, 8'h33, 1'b0); chk_stat("fill3", 3, 0, 0, 0, 1, 0, 0);
    cyc(1'b0, 1'b1, 8'h44, 1'b0); chk_stat("fill4", 4, 0, 1, 0, 1, 0, 0);

    // scenario 2: overflow on full, rejected word never read
    cyc(1'b0, 1'b1, 8'h55, 1'b0); chk_stat("overflow", 4, 0, 1, 0, 1, 1, 0);
    expect_read(8'h11);
    expect_read(8'h22);
    expect_read(8'h33);
    expect_read(8'h44);
    chk_stat("drain_after_ovf", 0, 1, 0, 1, 0, 1, 0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1); chk_stat("clr_ovf", 0, 1, 0, 1, 0, 0, 0);

    // scenario 3: simultaneous rd/wr on full, drain across pointer wrap
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    cyc(1'b0, 1'b1, 8'h33, 1'b0);
    cyc(1'b0, 1'b1, 8'h44, 1'b0); chk_stat("refill", 4, 0, 1, 0, 1, 0, 0);
    exp_q.push_back(8'h11);
    cyc(1'b1, 1'b1, 8'h66, 1'b0); chk_stat("full_rd_wr", 4, 0, 1, 0, 1, 0, 0);
    expect_read(8'h22);
    expect_read(8'h33);
    expect_read(8'h44);
    expect_read(8'h66);
    chk_stat("drain_wrap", 0, 1, 0, 1, 0, 0, 0);

    // scenario 4: underflow with paired write, clear, set-wins
    cyc(1'b1, 1'b1, 8'h77, 1'b0); chk_stat("empty_rd_wr", 1, 0, 0, 1, 0, 0, 1);
    chk_data("head_77", 8'h77);
    cyc(1'b0, 1'b0, 8'h00, 1'b1); chk_stat("clr_udf", 1, 0, 0, 1, 0, 0, 0);
    expect_read(8'h77);
    cyc(1'b1, 1'b0, 8'h00, 1'b1); chk_stat("set_wins", 0, 1, 0, 1, 0, 0, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1); chk_stat("clr_again", 0, 1, 0, 1, 0, 0, 0);

    // scenario 5: seeded random traffic against a queue model
    begin
      bit ovf_m, udf_m;
      void'($urandom(32'd42));
      ovf_m = 1'b0;
      udf_m = 1'b0;
      mdl_q.delete();
      for (int i = 0; i < 100; i++) begin
        logic r, w, c;
        logic [B-1:0] d;
        bit full_m, empty_m, wr_acc_m, rd_acc_m;
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        c = ($urandom_range(0, 7) == 0);
        d = 8'($urandom_range(0, 255));
        full_m   = (mdl_q.size() == 4);
        empty_m  = (mdl_q.size() == 0);
        wr_acc_m = w && (!full_m || r);
        rd_acc_m = r && !empty_m;
        ovf_m    = (w && full_m && !r) || (ovf_m && !c);
        udf_m    = (r && empty_m) || (udf_m && !c);
        if (rd_acc_m) exp_q.push_back(mdl_q.pop_front());
        if (wr_acc_m) mdl_q.push_back(d);
        cyc(r, w, d, c);
        chk_stat("random", mdl_q.size(), mdl_q.size() == 0, mdl_q.size() == 4,
                 mdl_q.size() <= 1, mdl_q.size() >= 3, ovf_m, udf_m);
        if (mdl_q.size() != 0) chk_data("random_head", mdl_q[0]);
      end
    end

    // scenario 6: asynchronous reset mid-operation
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    while (!bus.empty && exp_q.size() < 8) begin
      exp_q.push_back(bus.r_data);
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
    end
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'hC1, 1'b0);
    cyc(1'b0, 1'b1, 8'hC2, 1'b0);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0); chk_stat("pre_reset", 3, 0, 0, 0, 1, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_stat("async_reset", 0, 1, 0, 1, 0, 0, 0);
    bus.wr     = 1'b1;
    bus.w_data = 8'hEE;
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    chk_stat("wr_ignored_in_reset", 0, 1, 0, 1, 0, 0, 0);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 8'hA5, 1'b0); chk_stat("post_reset_write", 1, 0, 0, 1, 0, 0, 0);
    chk_data("post_reset_head", 8'hA5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_q_drained: %0d expected reads never observed, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
